// File: rtl/mem_ext_sp_bypass_pkg.sv
// Shared types and elaboration helpers for the 1R1W memory wrapper.
// Holds the bring-up FSM encoding, mask width derivation and parameter legality.
package mem_ext_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    SCRUB = 2'd1,
    READY = 2'd2
  } state_e;

  function automatic int calc_mask_w(input int data_w, input int mask_gran);
    return data_w / mask_gran;
  endfunction

  function automatic bit mask_cfg_ok(input int data_w, input int mask_gran);
    return (mask_gran > 0) && (data_w >= mask_gran) && ((data_w % mask_gran) == 0);
  endfunction

endpackage

// File: rtl/mem_ext_sp_bypass_if.sv
// Read/write port bundle of the memory wrapper; slave is the memory, master the client.
// Widths must match the parameters of the attached mem_ext_sp_bypass instance.
interface mem_ext_sp_bypass_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13,
  parameter int MASK_W = 8
);
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [DATA_W-1:0] R0_data;
  logic              R0_valid;
  logic [ADDR_W-1:0] W0_addr;
  logic              W0_en;
  logic [DATA_W-1:0] W0_data;
  logic [MASK_W-1:0] W0_mask;
  logic              init_done;

  modport master (
    output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    input  R0_data, R0_valid, init_done
  );

  modport slave (
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    output R0_data, R0_valid, init_done
  );
endinterface

// File: rtl/mem_ext_sp_bypass_lane.sv
// One mask-lane slice of the RAM: write port, registered read, write-first bypass.
// Read register holds its value whenever no read is issued.
module mem_ext_lane #(
  parameter int GRAN   = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [GRAN-1:0]   i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [GRAN-1:0]   o_rdata
);

  logic [GRAN-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [GRAN-1:0] r_rdata;
  logic            w_fwd;

  assign w_fwd = i_we && (i_waddr == i_raddr);

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Bypass keeps the read register from seeing the pre-write array word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_fwd ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_ext_sp_bypass.sv
// Parametrised single-clock 1R1W RAM wrapper with post-reset zero scrub; latency 1 (2 with MEM_OUT_REG_EN).
// Requests are ignored until init_done; read data holds on idle cycles.
module mem_ext_sp_bypass
  import mem_ext_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 13,
  parameter int MASK_GRAN      = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clock,
  input  logic               reset,
  mem_ext_sp_bypass_if.slave mem
);

  localparam int MASK_W = calc_mask_w(DATA_W, MASK_GRAN);

  generate
    if (!mask_cfg_ok(DATA_W, MASK_GRAN)) begin : g_bad_cfg
      $error("mem_ext_sp_bypass: DATA_W must be a non-zero multiple of MASK_GRAN");
    end
  endgenerate

  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_init_done;
  logic              r_vld;

  logic              w_scrub;
  logic              w_rd_req;
  logic              w_wr_req;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [MASK_W-1:0] w_we;
  logic [DATA_W-1:0] w_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_cnt   <= '0;
          r_state <= (CLEAR_ON_RESET != 0) ? SCRUB : READY;
        end
        SCRUB: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {ADDR_W{1'b1}}) begin
            r_state <= READY;
          end
        end
        READY: begin
          r_init_done <= 1'b1;
        end
        default: r_state <= INIT;
      endcase
    end
  end

  // The scrub owns the write port outright; client traffic waits for init_done.
  assign w_scrub  = (r_state == SCRUB);
  assign w_rd_req = r_init_done & mem.R0_en;
  assign w_wr_req = r_init_done & mem.W0_en;
  assign w_waddr  = w_scrub ? r_cnt : mem.W0_addr;
  assign w_wdata  = w_scrub ? '0 : mem.W0_data;
  assign w_we     = w_scrub ? {MASK_W{1'b1}} : (w_wr_req ? mem.W0_mask : '0);

  generate
    for (genvar i = 0; i < MASK_W; i++) begin : g_lane
      mem_ext_lane #(
        .GRAN   (MASK_GRAN),
        .ADDR_W (ADDR_W)
      ) u_lane (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_we[i]),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata[i*MASK_GRAN +: MASK_GRAN]),
        .i_re    (w_rd_req),
        .i_raddr (mem.R0_addr),
        .o_rdata (w_rdata[i*MASK_GRAN +: MASK_GRAN])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld <= 1'b0;
    end else begin
      r_vld <= w_rd_req;
    end
  end

`ifdef MEM_OUT_REG_EN
  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_dat;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
    end else begin
      r_out_vld <= r_vld;
      if (r_vld) begin
        r_out_dat <= w_rdata;
      end
    end
  end

  assign mem.R0_valid = r_out_vld;
  assign mem.R0_data  = r_out_dat;
`else
  assign mem.R0_valid = r_vld;
  assign mem.R0_data  = w_rdata;
`endif

  assign mem.init_done = r_init_done;

endmodule

// File: tb/tb_mem_ext_sp_bypass.sv
// Randomised and directed bench for mem_ext_sp_bypass at ADDR_W=4 against a word-level memory model.
module tb_mem_ext_sp_bypass;

`ifdef MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int MW = 8;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_ext_sp_bypass_if #(.DATA_W(DW), .ADDR_W(AW), .MASK_W(MW)) bus ();

  mem_ext_sp_bypass #(
    .DATA_W(DW), .ADDR_W(AW), .MASK_GRAN(8), .CLEAR_ON_RESET(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .mem   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  logic          m_ready;
  logic          pv [0:LAT-1];
  logic [DW-1:0] pd [0:LAT-1];
  logic          exp_vld;
  logic [DW-1:0] exp_dat;

  function automatic logic [DW-1:0] expand(input logic [MW-1:0] m);
    logic [DW-1:0] e;
    for (int i = 0; i < MW; i++) e[i*8 +: 8] = {8{m[i]}};
    return e;
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    for (int s = 0; s < LAT; s++) begin
      pv[s] = 1'b0;
      pd[s] = '0;
    end
    for (int a = 0; a < (1<<AW); a++) m_mem[a] = '0;
    exp_vld = 1'b0;
    exp_dat = '0;
  endtask

  // Advance one clock and apply the inputs present at that edge to the model.
  task automatic tick();
    logic          ren, wen;
    logic [DW-1:0] bm, rd;
    @(posedge clock);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      ren = m_ready && bus.R0_en;
      wen = m_ready && bus.W0_en;
      bm  = expand(bus.W0_mask);
      rd  = m_mem[bus.R0_addr];
      if (ren && wen && (bus.W0_addr == bus.R0_addr)) rd = (rd & ~bm) | (bus.W0_data & bm);
      if (wen) m_mem[bus.W0_addr] = (m_mem[bus.W0_addr] & ~bm) | (bus.W0_data & bm);
      for (int s = LAT-1; s > 0; s--) begin
        if (pv[s-1]) pd[s] = pd[s-1];
        pv[s] = pv[s-1];
      end
      if (ren) pd[0] = rd;
      pv[0] = ren;
      exp_vld = pv[LAT-1];
      exp_dat = pd[LAT-1];
    end
  endtask

  task automatic idle_inputs();
    bus.R0_en   = 1'b0;
    bus.R0_addr = '0;
    bus.W0_en   = 1'b0;
    bus.W0_addr = '0;
    bus.W0_data = '0;
    bus.W0_mask = '0;
  endtask

  // Counts post-release cycles with init_done low; returns 0 on timeout.
  task automatic wait_init(output int low_cycles, output bit seen);
    low_cycles = 0;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      tick();
      if (bus.init_done === 1'b1) seen = 1'b1;
      else low_cycles++;
    end
    m_ready = seen;
  endtask

  task automatic test_reset();
    int low;
    bit seen;
    bus.R0_en = 1'b1; bus.R0_addr = 4'd9;
    bus.W0_en = 1'b1; bus.W0_addr = 4'd9; bus.W0_data = '1; bus.W0_mask = '1;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (bus.R0_valid !== 1'b0 || bus.R0_data !== 64'h0 || bus.init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h init_done=%b required 0/0/0",
               bus.R0_valid, bus.R0_data, bus.init_done);
    end
    reset = 1'b0;
    wait_init(low, seen);
    n_checks++;
    if (!seen || low != 17) begin
      n_fail++;
      $display("FAIL init_done_delay: low cycles=%0d seen=%b required 17 then high", low, seen);
    end
    n_checks++;
    if (bus.R0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL init_ignores_read: valid=%b required 0", bus.R0_valid);
    end
    idle_inputs();
    for (int a = 0; a < 2; a++) begin
      bus.R0_en = 1'b1;
      bus.R0_addr = (a == 0) ? 4'd5 : 4'd9;
      tick();
      bus.R0_en = 1'b0;
      repeat (LAT-1) tick();
      n_checks++;
      if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h0) begin
        n_fail++;
        $display("FAIL scrubbed_read addr=%0d: valid=%b data=%h required 1/0", bus.R0_addr,
                 bus.R0_valid, bus.R0_data);
      end
    end
  endtask

  task automatic test_write_read();
    idle_inputs();
    bus.W0_en = 1'b1; bus.W0_addr = 4'd3; bus.W0_data = 64'h1122334455667788; bus.W0_mask = 8'hFF;
    tick();
    idle_inputs();
    bus.R0_en = 1'b1; bus.R0_addr = 4'd3;
    tick();
    bus.R0_en = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      n_checks++;
      if (bus.R0_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL out_reg_latency: valid=%b at stage %0d required 0", bus.R0_valid, k);
      end
      tick();
    end
    n_checks++;
    if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h1122334455667788) begin
      n_fail++;
      $display("FAIL write_read: valid=%b data=%h required 1/1122334455667788",
               bus.R0_valid, bus.R0_data);
    end
  endtask

  task automatic test_collision();
    idle_inputs();
    bus.R0_en = 1'b1; bus.R0_addr = 4'd3;
    bus.W0_en = 1'b1; bus.W0_addr = 4'd3; bus.W0_data = 64'hAAAAAAAAAAAAAAAA; bus.W0_mask = 8'h0F;
    tick();
    idle_inputs();
    repeat (LAT-1) tick();
    n_checks++;
    if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h11223344AAAAAAAA) begin
      n_fail++;
      $display("FAIL collision_fwd: valid=%b data=%h required 1/11223344aaaaaaaa",
               bus.R0_valid, bus.R0_data);
    end
  endtask

  task automatic test_hold();
    idle_inputs();
    bus.R0_en = 1'b1; bus.R0_addr = 4'd3;
    tick();
    bus.R0_en = 1'b0;
    bus.W0_en = 1'b1; bus.W0_addr = 4'd3; bus.W0_mask = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      bus.W0_data = {$urandom(), $urandom()};
      tick();
      n_checks++;
      if (bus.R0_valid !== exp_vld || bus.R0_data !== exp_dat) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid=%b data=%h required %b/%h", k,
                 bus.R0_valid, bus.R0_data, exp_vld, exp_dat);
      end
    end
    n_checks++;
    if (bus.R0_valid !== 1'b0 || bus.R0_data !== 64'h11223344AAAAAAAA) begin
      n_fail++;
      $display("FAIL hold_final: valid=%b data=%h required 0/11223344aaaaaaaa",
               bus.R0_valid, bus.R0_data);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [AW-1:0] wa;
    for (int c = 0; c < 400; c++) begin
      wa = AW'($urandom_range(0, (1<<AW)-1));
      bus.W0_en   = ($urandom_range(0, 2) != 0);
      bus.W0_addr = wa;
      bus.W0_data = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0:       bus.W0_mask = 8'h00;
        1:       bus.W0_mask = 8'hFF;
        default: bus.W0_mask = MW'($urandom());
      endcase
      bus.R0_en   = ($urandom_range(0, 3) != 0);
      bus.R0_addr = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, (1<<AW)-1));
      tick();
      n_checks++;
      if (bus.R0_valid !== exp_vld || bus.R0_data !== exp_dat) begin
        n_fail++;
        $display("FAIL random_cycle%0d: valid=%b data=%h required %b/%h", c,
                 bus.R0_valid, bus.R0_data, exp_vld, exp_dat);
      end
    end
    idle_inputs();
    repeat (LAT) tick();
  endtask

  task automatic test_reset_mid_scrub();
    int low;
    bit seen;
    bit early_done;
    idle_inputs();
    bus.W0_en = 1'b1; bus.W0_addr = 4'd12; bus.W0_data = '1; bus.W0_mask = 8'hFF;
    tick();
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    early_done = 1'b0;
    repeat (8) begin
      tick();
      if (bus.init_done !== 1'b0) early_done = 1'b1;
    end
    reset = 1'b1;
    repeat (2) begin
      tick();
      if (bus.init_done !== 1'b0) early_done = 1'b1;
    end
    n_checks++;
    if (early_done) begin
      n_fail++;
      $display("FAIL mid_scrub_init_done: init_done=1 seen before scrub end, required 0");
    end
    reset = 1'b0;
    wait_init(low, seen);
    n_checks++;
    if (!seen || low != 17) begin
      n_fail++;
      $display("FAIL scrub_restart: low cycles=%0d seen=%b required 17 then high", low, seen);
    end
    bus.R0_en = 1'b1; bus.R0_addr = 4'd12;
    tick();
    bus.R0_en = 1'b0;
    repeat (LAT-1) tick();
    n_checks++;
    if (bus.R0_valid !== 1'b1 || bus.R0_data !== 64'h0) begin
      n_fail++;
      $display("FAIL scrub_clears_addr12: valid=%b data=%h required 1/0",
               bus.R0_valid, bus.R0_data);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_write_read();
    test_collision();
    test_hold();
    test_random();
    test_reset_mid_scrub();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ext_sp_bypass.md
Name: mem_ext_sp_bypass

Overview:
- Parametrised single-clock 1R1W memory macro wrapper; successor to the fixed 64x8192 dual-clock byte-masked RAM wrapper.
- Generalised data width, address width and mask granularity.
- Adds:
  - registered read with a valid flag;
  - write-first forwarding on a same-address read/write collision;
  - read-data hold while idle;
  - a hardware zero-scrub FSM after reset.
- Sits between the Chisel-generated memory blackbox name and the inferred or vendor block RAM.

Parameters:
- DATA_W, 64, read/write data width in bits.
- ADDR_W, 13, address width; depth = 2**ADDR_W.
- MASK_GRAN, 8, bits per mask lane; DATA_W must be a multiple of it; MASK_W = DATA_W/MASK_GRAN.
- CLEAR_ON_RESET, 1, when 1, run the zero-scrub after reset; when 0, skip it.

Ports:
- clock  in  1  single clock for all ports.
- reset  in  1  synchronous, active-high.
- R0_addr  in  ADDR_W  read address.
- R0_en  in  1  read request.
- R0_data  out  DATA_W  read data.
- R0_valid  out  1  R0_data updated by a read this cycle.
- W0_addr  in  ADDR_W  write address.
- W0_en  in  1  write request.
- W0_data  in  DATA_W  write data.
- W0_mask  in  MASK_W  per-lane write enable; bit i covers bits [i*MASK_GRAN +: MASK_GRAN].
- init_done  out  1  scrub finished; port accepts requests.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high, ports named clock and reset.
- Reset values: R0_data=0, R0_valid=0, init_done=0, scrub counter=0, FSM=INIT.
- FSM INIT:
  - Lasts one cycle; ignores requests.
  - Goes to SCRUB if CLEAR_ON_RESET=1, else to READY.
- FSM SCRUB:
  - Writes all-zero with a full mask to address cnt each cycle, cnt=0..2**ADDR_W-1.
  - R0_en and W0_en are ignored; R0_valid=0.
  - After cnt wraps at 2**ADDR_W-1, goes to READY.
- FSM READY:
  - init_done=1, registered, first high the cycle after entering READY.
  - Stays in READY until reset.
- Reset at any time, including mid-scrub, returns to INIT with cnt=0. The scrub always restarts from address 0.
- Write (READY, W0_en=1): only lanes with mask bit 1 are updated at the clock edge. A W0_mask of all zeros is a no-op.
- Read latency is 1 cycle:
  - R0_en=1 at edge N gives R0_data = mem[R0_addr] and R0_valid=1 after edge N.
  - R0_en=0 at an edge holds R0_data at its previous value and sets R0_valid=0.
- Collision (R0_en & W0_en & addresses equal, same cycle), write-first per lane:
  - Lanes with mask=1 return W0_data.
  - Lanes with mask=0 return the old memory content.
- Different addresses in the same cycle are fully independent.
- No X on R0_data after reset.
- Addresses are always in range, since depth is a power of two.

Optional Feature:
- MEM_OUT_REG_EN defined:
  - Adds one output pipeline register: read latency 2. R0_valid and R0_data are delayed together.
  - The hold-on-idle rule applies to the final stage.
  - Forwarding is captured at request time, so collision data is identical to the undefined-macro case.
  - Both stages reset to 0.
- MEM_OUT_REG_EN undefined: latency 1 as above.

Decomposition:
- Package mem_ext_pkg holds:
  - FSM state enum {INIT, SCRUB, READY};
  - the localparam function computing MASK_W;
  - the parameter legality checks (DATA_W % MASK_GRAN == 0).
- Sub-module mem_ext_lane:
  - one MASK_GRAN-wide RAM lane with its own write enable, read register and collision mux;
  - instantiated MASK_W times via generate.
- The top level holds the FSM, the scrub counter, the request gating and the optional output stage.

Test Plan:
- Reset, ADDR_W=4, CLEAR_ON_RESET=1 -> init_done low for exactly 17 cycles after reset falls (INIT + 16 scrub), then high; reading addr 5 returns 0.
- Write addr 3 data 0x1122334455667788 mask 0xFF, then read addr 3 -> R0_data=0x1122334455667788, R0_valid=1 one cycle later.
- Addr 3 holds 0x1122334455667788; write 0xAAAAAAAAAAAAAAAA mask 0x0F while reading addr 3 in the same cycle -> R0_data=0x11223344AAAAAAAA (write-first forward).
- Read addr 3, then hold R0_en=0 for 4 cycles while writing addr 3 -> R0_data unchanged, R0_valid=0.
- Assert reset at scrub cnt=7 after writing 0xFF.. to addr 12 -> init_done stays 0, scrub restarts at 0, addr 12 later reads 0.
- With MEM_OUT_REG_EN: read addr 3 at edge N -> R0_valid=1 and data after edge N+1 only.
